// File: rtl/fifo_pkg.sv
// Shared definitions for the show-ahead FIFO and its read-side packer.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_FLUSH = 1'b1
  } rd_packer_state_t;

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops narrow words from a show-ahead FIFO and packs RATIO of them, little-endian,
// into one wide valid/ready beat; a flush forces out a partial beat marked last.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int RATIO      = 4,
  parameter int IDX_W      = $clog2(RATIO)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fifo_empty,
  input  logic [DATA_WIDTH-1:0]       fifo_rd_data,
  output logic                        fifo_rd_en,
  input  logic                        flush,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH*RATIO-1:0] m_data,
  output logic [RATIO-1:0]            m_keep,
  output logic                        m_last,
  output logic                        flush_done,
  output logic                        busy
);

  localparam int              BEAT_W   = DATA_WIDTH * RATIO;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  rd_packer_state_t  state_r, state_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic [BEAT_W-1:0] acc_r, acc_s;
  logic [RATIO-1:0]  keep_r, keep_s;
  logic [BEAT_W-1:0] full_beat_s;
  logic              out_free_s;
  logic              last_lane_s;
  logic              pop_s;
  logic              load_full_s;
  logic              load_part_s;
  logic              done_s;

  assign out_free_s  = ~m_valid | m_ready;
  assign last_lane_s = (idx_r == LAST_IDX);
  // The final lane is only popped when the output register can accept the beat.
  assign pop_s       = ~rst & (state_r == S_FILL) & ~fifo_empty & (~last_lane_s | out_free_s);
  assign fifo_rd_en  = pop_s;
  // Lane RATIO-1 of the accumulator is never written, so the head word takes its place.
  assign full_beat_s = {fifo_rd_data, acc_r[BEAT_W-DATA_WIDTH-1:0]};
  assign busy        = (state_r == S_FLUSH) | (idx_r != {IDX_W{1'b0}}) | m_valid;

  // Next-state, accumulator and beat-load decisions.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    acc_s       = acc_r;
    keep_s      = keep_r;
    load_full_s = 1'b0;
    load_part_s = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      S_FILL: begin
        if (pop_s && last_lane_s) begin
          load_full_s = 1'b1;
          idx_s       = {IDX_W{1'b0}};
          acc_s       = {BEAT_W{1'b0}};
          keep_s      = {RATIO{1'b0}};
        end else if (pop_s) begin
          for (int i = 0; i < RATIO; i++) begin
            acc_s[i*DATA_WIDTH +: DATA_WIDTH] = (idx_r == IDX_W'(i)) ? fifo_rd_data
                                                                     : acc_r[i*DATA_WIDTH +: DATA_WIDTH];
            keep_s[i] = keep_r[i] | (idx_r == IDX_W'(i));
          end
          idx_s = idx_r + IDX_W'(1);
        end else begin
          idx_s = idx_r;
        end
        if (flush) begin
          state_s = S_FLUSH;
        end else begin
          state_s = S_FILL;
        end
      end
      S_FLUSH: begin
        if (idx_r == {IDX_W{1'b0}}) begin
          done_s  = 1'b1;
          state_s = S_FILL;
        end else if (out_free_s) begin
          // Lanes at or above idx were never written since the last clear, so they read 0.
          load_part_s = 1'b1;
          done_s      = 1'b1;
          idx_s       = {IDX_W{1'b0}};
          acc_s       = {BEAT_W{1'b0}};
          keep_s      = {RATIO{1'b0}};
          state_s     = S_FILL;
        end else begin
          state_s = S_FLUSH;
        end
      end
      default: begin
        state_s = S_FILL;
      end
    endcase
  end

  // Packing state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FILL;
      idx_r   <= {IDX_W{1'b0}};
      acc_r   <= {BEAT_W{1'b0}};
      keep_r  <= {RATIO{1'b0}};
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      acc_r   <= acc_s;
      keep_r  <= keep_s;
    end
  end

  // Output beat register and flush completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= {BEAT_W{1'b0}};
      m_keep     <= {RATIO{1'b0}};
      m_last     <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= done_s;
      if (load_full_s) begin
        m_valid <= 1'b1;
        m_data  <= full_beat_s;
        m_keep  <= {RATIO{1'b1}};
        m_last  <= 1'b0;
      end else if (load_part_s) begin
        m_valid <= 1'b1;
        m_data  <= acc_r;
        m_keep  <= keep_r;
        m_last  <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Randomized and directed bench for fifo_rd_packer against a word-list packing model.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int R  = 4;

  logic          clk;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW*R-1:0] m_data;
  logic [R-1:0]  m_keep;
  logic          m_last;
  logic          flush_done;
  logic          busy;

  typedef struct {
    logic [DW*R-1:0] data;
    logic [R-1:0]    keep;
    logic            last;
  } beat_t;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pend[$];
  beat_t         exp_q[$];
  int            n_checks;
  int            n_fail;
  int            n_flush_req;
  int            n_flush_done;
  bit            flushing;
  bit            last_pop;
  int            pop_cnt;

  fifo_rd_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .flush_done(flush_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Turns the pending word list into an expected beat: word k lands in lane k.
  function automatic beat_t make_beat(input bit last);
    beat_t b;
    b.data = '0;
    b.keep = '0;
    b.last = last;
    for (int i = 0; i < pend.size(); i++) begin
      b.data[i*DW +: DW] = pend[i];
      b.keep[i]          = 1'b1;
    end
    pend.delete();
    return b;
  endfunction

  // One clock cycle: drive at the falling edge, sample 1ns later, update the model.
  task automatic step(input bit rdy, input bit fl);
    beat_t b;
    m_ready      = rdy;
    flush        = fl;
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = fifo_empty ? '0 : fifo_q[0];
    #1;
    if (flush_done) begin
      n_flush_done++;
      flushing = 1'b0;
    end
    check_eq("pop_when_empty", 64'(fifo_rd_en & fifo_empty), 64'd0);
    check_eq("pop_during_flush", 64'(fifo_rd_en & flushing), 64'd0);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_beat", 64'(m_valid), 64'd0);
      end else begin
        b = exp_q.pop_front();
        check_eq("beat_data", 64'(m_data), 64'(b.data));
        check_eq("beat_keep", 64'(m_keep), 64'(b.keep));
        check_eq("beat_last", 64'(m_last), 64'(b.last));
      end
    end
    last_pop = fifo_rd_en;
    if (fifo_rd_en) begin
      pop_cnt++;
      pend.push_back(fifo_q.pop_front());
      if (pend.size() == R) exp_q.push_back(make_beat(1'b0));
    end
    if (fl && !flushing) begin
      flushing = 1'b1;
      n_flush_req++;
      if (pend.size() > 0) exp_q.push_back(make_beat(1'b1));
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    n_checks = 0; n_fail = 0; n_flush_req = 0; n_flush_done = 0;
    flushing = 1'b0; last_pop = 1'b0; pop_cnt = 0;
    rst = 1'b1; fifo_empty = 1'b1; fifo_rd_data = '0; flush = 1'b0; m_ready = 1'b0;
    #1;
    check_eq("rst_m_valid", 64'(m_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Streaming: four back-to-back pops produce one full beat.
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      check_eq("stream_pop", 64'(last_pop), 64'd1);
    end
    check_eq("stream_valid", 64'(m_valid), 64'd1);
    check_eq("stream_data", 64'(m_data), 64'h44332211);
    check_eq("stream_keep", 64'(m_keep), 64'hf);
    check_eq("stream_last", 64'(m_last), 64'd0);
    step(1'b1, 1'b0);
    check_eq("stream_valid_fall", 64'(m_valid), 64'd0);

    // Backpressure: last lane is held back while the first beat waits.
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    pop_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      if (i >= 4) check_eq("bp_hold_data", 64'(m_data), 64'h44332211);
    end
    check_eq("bp_pops", 64'(pop_cnt), 64'd7);
    check_eq("bp_rd_en_low", 64'(last_pop), 64'd0);
    check_eq("bp_valid", 64'(m_valid), 64'd1);
    step(1'b1, 1'b0);
    check_eq("bp_beat2_data", 64'(m_data), 64'h88776655);
    check_eq("bp_beat2_keep", 64'(m_keep), 64'hf);
    step(1'b1, 1'b0);

    // Partial flush of two words.
    fifo_q = '{8'hAA, 8'hBB};
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check_eq("pf_no_beat_yet", 64'(m_valid), 64'd0);
    step(1'b1, 1'b0);
    check_eq("pf_valid", 64'(m_valid), 64'd1);
    check_eq("pf_data", 64'(m_data), 64'h0000BBAA);
    check_eq("pf_keep", 64'(m_keep), 64'h3);
    check_eq("pf_last", 64'(m_last), 64'd1);
    check_eq("pf_done", 64'(flush_done), 64'd1);
    step(1'b1, 1'b0);
    check_eq("pf_done_once", 64'(flush_done), 64'd0);
    check_eq("pf_busy_fall", 64'(busy), 64'd0);

    // Empty flush: only a completion pulse, never a beat.
    step(1'b1, 1'b1);
    check_eq("ef_valid0", 64'(m_valid), 64'd0);
    check_eq("ef_done0", 64'(flush_done), 64'd0);
    step(1'b1, 1'b0);
    check_eq("ef_valid1", 64'(m_valid), 64'd0);
    check_eq("ef_done1", 64'(flush_done), 64'd1);
    step(1'b1, 1'b0);
    check_eq("ef_done2", 64'(flush_done), 64'd0);

    // Flush coincident with the pop that completes a beat.
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check_eq("cf_data", 64'(m_data), 64'h44332211);
    check_eq("cf_last", 64'(m_last), 64'd0);
    check_eq("cf_done_early", 64'(flush_done), 64'd0);
    step(1'b1, 1'b0);
    check_eq("cf_done", 64'(flush_done), 64'd1);
    check_eq("cf_no_partial", 64'(m_valid), 64'd0);
    step(1'b1, 1'b0);
    check_eq("cf_still_idle", 64'(m_valid), 64'd0);

    // Asynchronous reset while a beat is held and a partial word is pending.
    fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    check_eq("ar_pre_valid", 64'(m_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_valid", 64'(m_valid), 64'd0);
    check_eq("ar_data", 64'(m_data), 64'd0);
    check_eq("ar_keep", 64'(m_keep), 64'd0);
    check_eq("ar_last", 64'(m_last), 64'd0);
    check_eq("ar_rd_en", 64'(fifo_rd_en), 64'd0);
    pend.delete();
    exp_q.delete();
    flushing = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("ar_busy", 64'(busy), 64'd0);

    // Random traffic, backpressure and flushes.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (fifo_q.size() < 16 && $urandom_range(0, 2) != 0) fifo_q.push_back(8'($urandom));
      end
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    // Drain everything out.
    guard = 0;
    while (fifo_q.size() > 0 && guard < 500) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check_eq("drain_fifo", 64'(fifo_q.size()), 64'd0);
    guard = 0;
    while (flushing && guard < 50) begin
      step(1'b1, 1'b0);
      guard++;
    end
    step(1'b1, 1'b1);
    guard = 0;
    while (flushing && guard < 50) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check_eq("final_flush_done", 64'(flushing), 64'd0);
    guard = 0;
    while ((exp_q.size() > 0 || m_valid) && guard < 50) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check_eq("exp_beats_left", 64'(exp_q.size()), 64'd0);
    check_eq("pend_words_left", 64'(pend.size()), 64'd0);
    check_eq("flush_done_count", 64'(n_flush_done), 64'(n_flush_req));
    check_eq("final_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
